// File: rtl/deserialize.sv
// rtl/deserialize.sv - framed serial-to-parallel receiver with valid/ack word output
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   data_in    serial line, one bit per clock, idles low
//   out_ack    consumer accepts out_data at an edge where out_valid is high
//   out_data   last good word received
//   out_valid  out_data holds an unconsumed word
//   frame_err  one-cycle pulse: frame rejected (bad stop bit or bad parity)
//   overrun    one-cycle pulse: good frame dropped because the old word is unread
module deserialize #(
    parameter int WIDTH  = 8,
    parameter int PARITY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             out_ack,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shreg;
    logic             par_acc;
    logic             par_ok;
    logic             frame_done;
    logic             frame_good;
    logic             load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (data_in) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (count == LAST) begin
                    state_nxt = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR:     state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // par_ok stays set from the start bit onward when there is no parity bit,
    // so the stop-bit check alone decides the frame in that configuration.
    always_comb begin
        frame_done = 1'b0;
        frame_good = 1'b0;
        load       = 1'b0;
        if (state == STOP) begin
            frame_done = 1'b1;
            frame_good = !data_in && par_ok;
            load       = frame_good && (!out_valid || out_ack);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
            par_ok  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (data_in) begin
                        count   <= '0;
                        shreg   <= '0;
                        par_acc <= 1'b0;
                        par_ok  <= 1'b1;
                    end
                end
                DATA: begin
                    shreg[count] <= data_in;
                    count        <= count + 1'b1;
                    par_acc      <= par_acc ^ data_in;
                end
                PAR: begin
                    par_ok <= (data_in == par_acc);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (load) begin
                // A load at the same edge as an ack keeps out_valid high.
                out_data  <= shreg;
                out_valid <= 1'b1;
            end else begin
                if (out_valid && out_ack) begin
                    out_valid <= 1'b0;
                end
                if (frame_done && !frame_good) begin
                    frame_err <= 1'b1;
                end
                // Good but not loaded means the previous word is still unread.
                if (frame_good) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_deserialize.sv
// tb/tb_deserialize.sv - self-checking bench for deserialize
module tb_deserialize;

    localparam int W = 8;
    localparam int P = 1;
    localparam int L = 1 + W + P + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         data_in;
    logic         out_ack;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         frame_err;
    logic         overrun;

    logic         dl_in;
    logic [2:0]   dl;
    logic         ack4;
    logic [3:0]   data4;
    logic         valid4;
    logic         ferr4;
    logic         ovr4;

    int checks = 0;
    int errors = 0;
    bit model_en = 1'b0;
    int rises = 0;
    logic prev_valid = 1'b0;

    deserialize #(.WIDTH(W), .PARITY(P)) u_dut (
        .clk(clk), .reset(reset), .data_in(data_in), .out_ack(out_ack),
        .out_data(out_data), .out_valid(out_valid), .frame_err(frame_err), .overrun(overrun)
    );

    deserialize #(.WIDTH(4), .PARITY(0)) u_dut4 (
        .clk(clk), .reset(reset), .data_in(dl[2]), .out_ack(ack4),
        .out_data(data4), .out_valid(valid4), .frame_err(ferr4), .overrun(ovr4)
    );

    always #5 clk = ~clk;

    // three-stage delay line in front of the narrow instance
    always @(posedge clk or posedge reset) begin
        if (reset) dl <= 3'b000;
        else       dl <= {dl[1:0], dl_in};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: collect the bits after a start bit into a queue and
    // judge the whole frame arithmetically once it is complete.
    bit           m_busy = 1'b0;
    bit           m_bits[$];
    logic [W-1:0] m_data = '0;
    logic         m_valid = 1'b0;
    logic         m_ferr = 1'b0;
    logic         m_ovr = 1'b0;
    int unsigned  m_word;
    bit           m_done;
    bit           m_good;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
            m_bits.delete();
            m_data = '0;
            m_valid = 1'b0;
            m_ferr = 1'b0;
            m_ovr = 1'b0;
        end else begin
            m_ferr = 1'b0;
            m_ovr = 1'b0;
            m_done = 1'b0;
            m_good = 1'b0;
            if (!m_busy) begin
                if (data_in) begin
                    m_busy = 1'b1;
                    m_bits.delete();
                end
            end else begin
                m_bits.push_back(data_in);
                if (m_bits.size() == L - 1) begin
                    m_word = 0;
                    for (int i = 0; i < W; i++) m_word |= int'(m_bits[i]) << i;
                    m_done = 1'b1;
                    m_good = (m_bits[L-2] == 1'b0) && (($countones(m_word) % 2) == int'(m_bits[W]));
                    m_busy = 1'b0;
                end
            end
            if (m_good && (!m_valid || out_ack)) begin
                m_data = m_word[W-1:0];
                m_valid = 1'b1;
            end else begin
                if (m_good) m_ovr = 1'b1;
                if (m_done && !m_good) m_ferr = 1'b1;
                if (m_valid && out_ack) m_valid = 1'b0;
            end
        end
        #1;
        if (reset) rises = 0;
        else if (out_valid === 1'b1 && prev_valid === 1'b0) rises++;
        prev_valid = out_valid;
        if (model_en) begin
            chk("cyc_out_data", 32'(out_data), 32'(m_data));
            chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
            chk("cyc_frame_err", 32'(frame_err), 32'(m_ferr));
            chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    task automatic drive(input logic b, input logic ack);
        @(negedge clk);
        data_in = b;
        out_ack = ack;
    endtask

    task automatic send_body(input logic [7:0] d, input logic pbit, input logic sbit, input logic ack_last);
        for (int i = 0; i < 8; i++) drive(d[i], 1'b0);
        drive(pbit, 1'b0);
        drive(sbit, ack_last);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input logic ack_last);
        drive(1'b1, 1'b0);
        send_body(d, pbit, sbit, ack_last);
    endtask

    task automatic drive4(input logic b);
        @(negedge clk);
        dl_in = b;
    endtask

    logic [7:0] rd;
    logic       rp;
    logic       rs;
    int         gap;

    initial begin
        reset = 1'b1;
        data_in = 1'b0;
        out_ack = 1'b0;
        dl_in = 1'b0;
        ack4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_flags", 32'({frame_err, overrun}), 32'h0);
        chk("rst_dut4", 32'({data4, valid4, ferr4, ovr4}), 32'h0);
        reset = 1'b0;
        model_en = 1'b1;

        // single frame 0xA5, even parity 0
        drive(1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        chk("a5_valid_before_stop", 32'(out_valid), 32'h0);
        drive(1'b0, 1'b0);
        chk("a5_valid", 32'(out_valid), 32'h1);
        chk("a5_data", 32'(out_data), 32'hA5);
        chk("a5_model_data", 32'(m_data), 32'hA5);
        chk("a5_no_flags", 32'({frame_err, overrun}), 32'h0);

        // handshake
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        chk("ack_valid_low", 32'(out_valid), 32'h0);
        chk("ack_data_kept", 32'(out_data), 32'hA5);

        // parity error
        send_frame(8'h01, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("par_err_pulse", 32'(frame_err), 32'h1);
        chk("par_err_model", 32'(m_ferr), 32'h1);
        chk("par_err_valid", 32'(out_valid), 32'h0);
        drive(1'b0, 1'b0);
        chk("par_err_one_cycle", 32'(frame_err), 32'h0);

        // stop error, then a frame whose start bit directly follows the bad stop bit
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk("stop_err_pulse", 32'(frame_err), 32'h1);
        send_body(8'h66, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("after_stop_err_valid", 32'(out_valid), 32'h1);
        chk("after_stop_err_data", 32'(out_data), 32'h66);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);

        // back-to-back, no ack: overrun
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("ovr_pulse", 32'(overrun), 32'h1);
        chk("ovr_data_kept", 32'(out_data), 32'h3C);
        chk("ovr_valid", 32'(out_valid), 32'h1);
        chk("ovr_no_ferr", 32'(frame_err), 32'h0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        chk("ovr_cleared", 32'(out_valid), 32'h0);

        // back-to-back, ack at the second frame's final edge
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0);
        chk("ackload_data", 32'(out_data), 32'hC3);
        chk("ackload_valid", 32'(out_valid), 32'h1);
        chk("ackload_no_ovr", 32'(overrun), 32'h0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);

        // reset after 4 data bits
        drive(1'b1, 1'b0);
        repeat (4) drive(1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        data_in = 1'b0;
        #1;
        chk("midrst_outputs", 32'({out_data, out_valid, frame_err, overrun}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        chk("midrst_data", 32'(out_data), 32'h5A);
        chk("midrst_one_word", 32'(rises), 32'h1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);

        // narrow instance through the delay line: 0x9, no parity
        drive4(1'b1);
        drive4(1'b1);
        drive4(1'b0);
        drive4(1'b0);
        drive4(1'b1);
        drive4(1'b0);
        @(negedge clk);
        dl_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("dl_valid_before", 32'(valid4), 32'h0);
        @(negedge clk);
        chk("dl_valid", 32'(valid4), 32'h1);
        chk("dl_data", 32'(data4), 32'h9);
        chk("dl_no_flags", 32'({ferr4, ovr4}), 32'h0);

        // randomized traffic with corruption, random ack and occasional resets
        for (int n = 0; n < 250; n++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) drive(1'b0, ($urandom_range(0, 2) == 0));
            rd = 8'($urandom);
            rp = ^rd;
            if ($urandom_range(0, 5) == 0) rp = ~rp;
            rs = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) begin
                drive(1'b1, 1'b0);
                repeat ($urandom_range(0, 9)) drive(1'($urandom), 1'b0);
                @(negedge clk);
                reset = 1'b1;
                data_in = 1'b0;
                @(negedge clk);
                reset = 1'b0;
            end
            drive(1'b1, ($urandom_range(0, 2) == 0));
            for (int i = 0; i < 8; i++) drive(rd[i], ($urandom_range(0, 2) == 0));
            drive(rp, ($urandom_range(0, 2) == 0));
            drive(rs, ($urandom_range(0, 2) == 0));
        end
        repeat (4) drive(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
